led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
Sequencer for the 8-LED bar of the TM1638 board. It selects one of four step patterns: fill, unfill, chase and blink. It paces the pattern with an internal prescaler and provides run, pause and stop control from the key/state logic. Its led output drives the TM1638 LED register image directly.

Parameters:
TICK_DIV, 25000000, clk cycles per pattern step (legal range 1..2^CNT_W)
CNT_W, 25, prescaler counter width

Ports:
clk  in  1  system clock
rs  in  1  synchronous active-low reset
start  in  1  pulse: run from IDLE, or resume from PAUSE
stop  in  1  pulse: pause from RUN, or clear from PAUSE
mode_sel  in  2  pattern select; 0 FILL, 1 UNFILL, 2 CHASE, 3 BLINK
mode_load  in  1  pulse: latch mode_sel
led  out  8  LED pattern
busy  out  1  high when the state is not IDLE
step  out  1  one-cycle pulse, coincident with each new led value
wrap  out  1  one-cycle pulse when a step returns led to the seed

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock is clk, reset is rs; rs==0 at a clk rising edge resets the block.
- Reset values:
  - state=IDLE, mode=FILL, prescaler=0
  - led=0x00, busy=0, step=0, wrap=0
- Seeds: FILL 0x00, UNFILL 0xFF, CHASE 0x01, BLINK 0x00.
- Next-value rules, evaluated on a step:
  - FILL: led==0xFF ? 0x00 : {led[6:0],1}
  - UNFILL: led==0x00 ? 0xFF : {led[6:0],0}
  - CHASE: {led[6:0],led[7]}
  - BLINK: ~led
- wrap=1 together with step when the new led equals the current mode's seed.
- IDLE:
  - led is held at 0x00.
  - start: next edge goes to RUN, led=seed(mode), prescaler=0.
- RUN:
  - The prescaler counts 0..TICK_DIV-1.
  - On the edge after count==TICK_DIV-1: led=next, step=1, prescaler=0.
  - With TICK_DIV=1, a step occurs every cycle.
- RUN + stop: go to PAUSE. led and prescaler freeze; no step.
- PAUSE + start: go to RUN. The prescaler resumes from its frozen value.
- PAUSE + stop: go to IDLE, led=0x00, prescaler=0.
- start and stop in the same cycle: stop wins. In IDLE, both are ignored.
- mode_load, any state:
  - mode<=mode_sel.
  - In RUN or PAUSE, next edge also sets led=seed(new mode), prescaler=0, step=0; state is unchanged.
  - Combined with stop, both actions apply.
- busy is registered and equals (state!=IDLE) after each edge.
- Reset mid-run: all registers return to reset values on that edge; any pending step is lost.

Optional Feature:
LEDCTRL_BOUNCE_EN
- Defined: CHASE is ping-pong using an internal direction bit (reset=left).
  - Moving left, led<<1; reaching 0x80 flips the bit to right.
  - Moving right, led>>1; reaching 0x01 flips the bit to left and asserts wrap.
  - A full cycle takes 14 steps.
  - The direction bit is cleared on reseed.
- Undefined: CHASE rotates left only; wrap fires every 8 steps.

Decomposition:
- Package ledctrl_pkg:
  - mode encodings MODE_FILL/UNFILL/CHASE/BLINK
  - state encodings ST_IDLE/ST_RUN/ST_PAUSE
  - seed constants, and the seed_of(mode) function
- Sub-module led_tick_gen: prescaler with clr and en inputs and a tick output, parameterised by TICK_DIV and CNT_W. The controller FSM and pattern register stay in led_pattern_ctrl.

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset, mode FILL, start -> led=0x00, then every 4 cycles 0x01,0x03,0x07,...,0xFF,0x00; wrap only on the 9th step (0x00).
2. mode_load UNFILL in IDLE, start -> 0xFF,0xFE,0xFC,...,0x00,0xFF; wrap on the 9th step.
3. CHASE -> 0x01,0x02,...,0x80,0x01; wrap on the 8th step. With LEDCTRL_BOUNCE_EN: 0x80,0x40,...,0x01; wrap on the 14th step.
4. FILL at led=0x07, stop -> led holds 0x07 for 20 cycles with no step. Then start -> led becomes 0x0F after the remaining prescaler count. Then stop, stop -> IDLE, led=0x00, busy=0.
5. RUN FILL, mode_load with mode_sel=3 -> led=0x00 next cycle, then toggles 0xFF/0x00 every 4 cycles. In IDLE, start+stop in the same cycle -> busy stays 0.
6. rs=0 for one cycle during RUN at led=0x3F -> next edge: led=0x00, busy=0, step=0, mode FILL.

Source files
------------

// File: rtl/ledctrl_pkg.sv
// Shared encodings for the TM1638 LED-bar sequencer: pattern modes, controller
// states and the per-mode seed values.
package ledctrl_pkg;

  typedef enum logic [1:0] {
    MODE_FILL   = 2'd0,
    MODE_UNFILL = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [7:0] SEED_FILL   = 8'h00;
  localparam logic [7:0] SEED_UNFILL = 8'hFF;
  localparam logic [7:0] SEED_CHASE  = 8'h01;
  localparam logic [7:0] SEED_BLINK  = 8'h00;

  function automatic logic [7:0] seed_of(input mode_e m);
    case (m)
      MODE_FILL:   seed_of = SEED_FILL;
      MODE_UNFILL: seed_of = SEED_UNFILL;
      MODE_CHASE:  seed_of = SEED_CHASE;
      default:     seed_of = SEED_BLINK;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal
// count; clr forces the count back to zero and takes priority over en.
module led_tick_gen #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic clk,
  input  logic rs,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == CNT_MAX);
  assign tick_o = en_i && at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rs) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// TM1638 8-LED bar sequencer with run/pause/stop control and four step patterns.
// Define LEDCTRL_BOUNCE_EN to make CHASE ping-pong instead of rotating left.
module led_pattern_ctrl
  import ledctrl_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode_sel,
  input  logic       mode_load,
  output logic [7:0] led,
  output logic       busy,
  output logic       step,
  output logic       wrap
);

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d, ld_mode;
  logic [7:0] led_q, led_d, nxt;
  logic       dir_q, dir_d, nxt_dir;
  logic       busy_q, step_q, step_d, wrap_q, wrap_d;
  logic       tick, tick_en, tick_clr;

  // Prescaler only advances in RUN when nothing else claims this edge.
  assign tick_en  = (state_q == ST_RUN) && !stop && !mode_load;
  assign tick_clr = (state_q == ST_IDLE) || mode_load || ((state_q == ST_PAUSE) && stop);
  assign ld_mode  = mode_load ? mode_e'(mode_sel) : mode_q;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rs    (rs),
    .clr_i (tick_clr),
    .en_i  (tick_en),
    .tick_o(tick)
  );

  always_comb begin
    nxt     = led_q;
    nxt_dir = dir_q;
    case (mode_q)
      MODE_FILL:   nxt = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
      MODE_UNFILL: nxt = (led_q == 8'h00) ? 8'hFF : {led_q[6:0], 1'b0};
      MODE_CHASE: begin
`ifdef LEDCTRL_BOUNCE_EN
        // dir_q=0 moves left; the bit flips on arrival at either end.
        if (!dir_q) begin
          nxt     = {led_q[6:0], 1'b0};
          nxt_dir = (nxt == 8'h80);
        end else begin
          nxt     = {1'b0, led_q[7:1]};
          nxt_dir = (nxt != 8'h01);
        end
`else
        nxt = {led_q[6:0], led_q[7]};
`endif
      end
      default:     nxt = ~led_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = ld_mode;
    led_d   = led_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        led_d = 8'h00;
        dir_d = 1'b0;
        if (start && !stop) begin
          state_d = ST_RUN;
          led_d   = seed_of(ld_mode);
        end
      end
      ST_RUN: begin
        if (stop) state_d = ST_PAUSE;
        if (mode_load) begin
          led_d = seed_of(ld_mode);
          dir_d = 1'b0;
        end else if (tick) begin
          led_d  = nxt;
          dir_d  = nxt_dir;
          step_d = 1'b1;
          wrap_d = (nxt == seed_of(mode_q));
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          led_d   = 8'h00;
          dir_d   = 1'b0;
        end else begin
          if (start) state_d = ST_RUN;
          if (mode_load) begin
            led_d = seed_of(ld_mode);
            dir_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = 8'h00;
        dir_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rs) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FILL;
      led_q   <= 8'h00;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      busy_q  <= (state_d != ST_IDLE);
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with TICK_DIV=4: pattern sequences,
// pause/resume, reseeding on mode_load, control priority and mid-run reset.
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rs = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_load = 1'b0;
  logic [7:0] led;
  logic       busy, step, wrap;

  int checks = 0;
  int failures = 0;

  logic [7:0] fill_v   [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
  logic [7:0] unfill_v [9] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'hFF};
`ifdef LEDCTRL_BOUNCE_EN
  localparam int CHASE_N = 14;
  logic [7:0] chase_v [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
`else
  localparam int CHASE_N = 8;
  logic [7:0] chase_v [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
`endif

  led_pattern_ctrl #(
    .TICK_DIV(4),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rs       (rs),
    .start    (start),
    .stop     (stop),
    .mode_sel (mode_sel),
    .mode_load(mode_load),
    .led      (led),
    .busy     (busy),
    .step     (step),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are observed at that point.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  task automatic load_mode(input logic [1:0] m);
    mode_sel = m; mode_load = 1'b1; cycle(); mode_load = 1'b0;
  endtask

  task automatic test_reset();
    rs = 1'b0;
    repeat (2) cycle();
    rs = 1'b1;
    cycle();
    checks++;
    if (led !== 8'h00 || busy !== 1'b0 || step !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset led=%h busy=%b step=%b wrap=%b required 00/0/0/0", led, busy, step, wrap);
    end
  endtask

  task automatic test_fill();
    pulse_start();
    checks++;
    if (led !== 8'h00 || busy !== 1'b1 || step !== 1'b0) begin
      failures++;
      $display("FAIL fill_seed led=%h busy=%b step=%b required 00/1/0", led, busy, step);
    end
    for (int k = 0; k < 9; k++) begin
      repeat (3) cycle();
      checks++;
      if (step !== 1'b0) begin
        failures++;
        $display("FAIL fill_gap k=%0d step=%b required 0", k, step);
      end
      cycle();
      checks++;
      if (led !== fill_v[k] || step !== 1'b1 || wrap !== (k == 8)) begin
        failures++;
        $display("FAIL fill_step k=%0d led=%h step=%b wrap=%b required %h/1/%b",
                 k, led, step, wrap, fill_v[k], (k == 8));
      end
    end
    pulse_stop();
    pulse_stop();
  endtask

  task automatic test_unfill();
    load_mode(2'd1);
    checks++;
    if (led !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL unfill_idle_load led=%h busy=%b required 00/0", led, busy);
    end
    pulse_start();
    checks++;
    if (led !== 8'hFF || busy !== 1'b1) begin
      failures++;
      $display("FAIL unfill_seed led=%h busy=%b required FF/1", led, busy);
    end
    for (int k = 0; k < 9; k++) begin
      repeat (4) cycle();
      checks++;
      if (led !== unfill_v[k] || step !== 1'b1 || wrap !== (k == 8)) begin
        failures++;
        $display("FAIL unfill_step k=%0d led=%h step=%b wrap=%b required %h/1/%b",
                 k, led, step, wrap, unfill_v[k], (k == 8));
      end
    end
    pulse_stop();
    pulse_stop();
  endtask

  task automatic test_chase();
    load_mode(2'd2);
    pulse_start();
    checks++;
    if (led !== 8'h01) begin
      failures++;
      $display("FAIL chase_seed led=%h required 01", led);
    end
    for (int k = 0; k < CHASE_N; k++) begin
      repeat (4) cycle();
      checks++;
      if (led !== chase_v[k] || step !== 1'b1 || wrap !== (k == CHASE_N - 1)) begin
        failures++;
        $display("FAIL chase_step k=%0d led=%h step=%b wrap=%b required %h/1/%b",
                 k, led, step, wrap, chase_v[k], (k == CHASE_N - 1));
      end
    end
    pulse_stop();
    pulse_stop();
  endtask

  task automatic test_pause();
    int bad;
    load_mode(2'd0);
    pulse_start();
    repeat (12) cycle();
    checks++;
    if (led !== 8'h07 || step !== 1'b1) begin
      failures++;
      $display("FAIL pause_pre led=%h step=%b required 07/1", led, step);
    end
    repeat (2) cycle();
    pulse_stop();
    checks++;
    if (busy !== 1'b1 || led !== 8'h07 || step !== 1'b0) begin
      failures++;
      $display("FAIL pause_enter busy=%b led=%h step=%b required 1/07/0", busy, led, step);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (led !== 8'h07 || step !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL pause_hold bad_cycles=%0d required 0", bad);
    end
    pulse_start();
    checks++;
    if (led !== 8'h07 || step !== 1'b0) begin
      failures++;
      $display("FAIL resume_wait led=%h step=%b required 07/0", led, step);
    end
    cycle();
    checks++;
    if (led !== 8'h07 || step !== 1'b0) begin
      failures++;
      $display("FAIL resume_cnt3 led=%h step=%b required 07/0", led, step);
    end
    cycle();
    checks++;
    if (led !== 8'h0F || step !== 1'b1) begin
      failures++;
      $display("FAIL resume_step led=%h step=%b required 0F/1", led, step);
    end
    pulse_stop();
    pulse_stop();
    checks++;
    if (led !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_stop led=%h busy=%b required 00/0", led, busy);
    end
  endtask

  task automatic test_blink_reload();
    logic [7:0] exp;
    pulse_start();
    repeat (6) cycle();
    load_mode(2'd3);
    checks++;
    if (led !== 8'h00 || step !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL blink_reseed led=%h step=%b busy=%b required 00/0/1", led, step, busy);
    end
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 8'hFF : 8'h00;
      repeat (4) cycle();
      checks++;
      if (led !== exp || step !== 1'b1 || wrap !== (k % 2 == 1)) begin
        failures++;
        $display("FAIL blink_step k=%0d led=%h step=%b wrap=%b required %h/1/%b",
                 k, led, step, wrap, exp, (k % 2 == 1));
      end
    end
    pulse_stop();
    pulse_stop();
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || led !== 8'h00) begin
      failures++;
      $display("FAIL idle_start_stop busy=%b led=%h required 0/00", busy, led);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    load_mode(2'd0);
    pulse_start();
    repeat (5) cycle();
    mode_sel = 2'd1; mode_load = 1'b1; stop = 1'b1;
    cycle();
    mode_load = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b1 || led !== 8'hFF || step !== 1'b0) begin
      failures++;
      $display("FAIL load_stop busy=%b led=%h step=%b required 1/FF/0", busy, led, step);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (led !== 8'hFF || step !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL load_stop_hold bad_cycles=%0d required 0", bad);
    end
    pulse_start();
    repeat (4) cycle();
    checks++;
    if (led !== 8'hFE || step !== 1'b1) begin
      failures++;
      $display("FAIL load_stop_resume led=%h step=%b required FE/1", led, step);
    end
    pulse_stop();
    pulse_stop();
  endtask

  task automatic test_reset_mid_run();
    load_mode(2'd0);
    pulse_start();
    repeat (24) cycle();
    checks++;
    if (led !== 8'h3F || step !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre led=%h step=%b required 3F/1", led, step);
    end
    repeat (3) cycle();
    rs = 1'b0;
    cycle();
    rs = 1'b1;
    checks++;
    if (led !== 8'h00 || busy !== 1'b0 || step !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset led=%h busy=%b step=%b wrap=%b required 00/0/0/0", led, busy, step, wrap);
    end
    pulse_start();
    repeat (4) cycle();
    checks++;
    if (led !== 8'h01 || step !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_mode led=%h step=%b required 01/1", led, step);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_unfill();
    test_chase();
    test_pause();
    test_blink_reload();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
